// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD character streamer.
// Init command table, row addresses and FSM encodings.
package lcd_pkg;

   localparam int INIT_LEN = 4;

   // Element 0 is sent first: function set, display on, entry mode, clear.
   localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
      8'h01, 8'h06, 8'h0C, 8'h38
   };

   localparam logic [7:0] LCD_ROW0 = 8'h80;
   localparam logic [7:0] LCD_ROW1 = 8'hC0;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_word_t;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_ADDR,
      ST_FETCH,
      ST_XFER,
      ST_FIN
   } lcd_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SETUP,
      TX_PULSE,
      TX_HOLD
   } tx_state_t;

   typedef enum logic [1:0] {
      M_INIT,
      M_ADDR,
      M_CHAR
   } xfer_mode_t;

   // Clear and return-home need the long settle time.
   function automatic logic is_slow_cmd(lcd_word_t w);
      return !w.rs && (w.data inside {8'h01, 8'h02, 8'h03});
   endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD bus write: setup, enable pulse, then settle wait.
// Single req starts it, single-cycle ack reports completion.
module lcd_byte_tx
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC    = 4,
   parameter int EN_CYC       = 12,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  lcd_word_t  word,
   output logic       ack,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   localparam int M1 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int M2 = (CMD_WAIT_CYC > CLR_WAIT_CYC) ?
                       CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int MAXW = (M1 > M2) ? M1 : M2;
   localparam int TW = $clog2(MAXW) + 1;

   tx_state_t     st;
   logic [TW-1:0] tmr;
   logic          slow;

   assign slow = is_slow_cmd(lcd_word_t'({lcd_rs, lcd_data}));

   // Transfer sequencer; bus pins are registered and only move on entry to setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= TX_IDLE;
         tmr      <= '0;
         ack      <= 1'b0;
         lcd_en   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= '0;
      end else begin
         ack <= 1'b0;
         unique case (st)
            TX_IDLE: begin
               if (req) begin
                  lcd_rs   <= word.rs;
                  lcd_data <= word.data;
                  tmr      <= TW'(SETUP_CYC - 1);
                  st       <= TX_SETUP;
               end
            end
            TX_SETUP: begin
               if (tmr != '0) begin
                  tmr <= tmr - TW'(1);
               end else begin
                  lcd_en <= 1'b1;
                  tmr    <= TW'(EN_CYC - 1);
                  st     <= TX_PULSE;
               end
            end
            TX_PULSE: begin
               if (tmr != '0) begin
                  tmr <= tmr - TW'(1);
               end else begin
                  lcd_en <= 1'b0;
                  tmr    <= slow ? TW'(CLR_WAIT_CYC - 1)
                                 : TW'(CMD_WAIT_CYC - 1);
                  st     <= TX_HOLD;
               end
            end
            TX_HOLD: begin
               if (tmr != '0) begin
                  tmr <= tmr - TW'(1);
               end else begin
                  ack <= 1'b1;
                  st  <= TX_IDLE;
               end
            end
            default: st <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_char_streamer.sv
// Streams 9-bit {rs,byte} words from character memory to an HD44780 bus.
// Power-up wait, init table, then row-addressed passes on start.
module lcd_char_streamer
   import lcd_pkg::*;
#(
   parameter int NUM_CHARS    = 32,
   parameter int ADDR_W       = 6,
   parameter int PWRUP_CYC    = 750000,
   parameter int SETUP_CYC    = 4,
   parameter int EN_CYC       = 12,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic [7:0]        lcd_data,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic              lcd_en,
   output logic              busy,
   output logic              done
);

   localparam int PW = $clog2(PWRUP_CYC) + 1;

   logic [1:0]    rst_sync;
   logic          rst_i;
   lcd_state_t    st;
   xfer_mode_t    mode;
   logic [PW-1:0] pwr_cnt;
   logic [1:0]    init_k;
   logic [5:0]    idx;
   logic [5:0]    idx_n;
   logic          fetch_ph;
   logic          req;
   lcd_word_t     word;
   logic          ack;
   logic          unused_rd;

   assign lcd_rw    = 1'b0;
   assign idx_n     = idx + 6'd1;
   assign unused_rd = ^rd_data[31:9];

   // Reset asserts at once, releases two clocks later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_i = rst_sync[1];

   // Sequencing: power-up, init table, row address, memory words.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         st       <= ST_PWRUP;
         mode     <= M_INIT;
         pwr_cnt  <= '0;
         init_k   <= '0;
         idx      <= '0;
         fetch_ph <= 1'b0;
         req      <= 1'b0;
         word     <= '0;
         rd_addr  <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         req  <= 1'b0;
         done <= 1'b0;
         unique case (st)
            ST_PWRUP: begin
               if (pwr_cnt == PW'(PWRUP_CYC - 1)) begin
                  init_k <= '0;
                  st     <= ST_INIT;
               end else begin
                  pwr_cnt <= pwr_cnt + PW'(1);
               end
            end
            ST_INIT: begin
               req  <= 1'b1;
               word <= '{rs: 1'b0, data: INIT_SEQ[init_k]};
               mode <= M_INIT;
               st   <= ST_XFER;
            end
            ST_IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  idx  <= '0;
                  st   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               req  <= 1'b1;
               word <= '{rs: 1'b0,
                         data: (idx == '0) ? LCD_ROW0 : LCD_ROW1};
               mode <= M_ADDR;
               st   <= ST_XFER;
            end
            ST_FETCH: begin
               if (!fetch_ph) begin
                  fetch_ph <= 1'b1;
               end else begin
                  fetch_ph <= 1'b0;
                  req      <= 1'b1;
                  word     <= lcd_word_t'(rd_data[8:0]);
                  mode     <= M_CHAR;
                  st       <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (ack) begin
                  unique case (mode)
                     M_INIT: begin
                        if (init_k == 2'(INIT_LEN - 1)) begin
                           idx <= '0;
                           st  <= ST_ADDR;
                        end else begin
                           init_k <= init_k + 2'd1;
                           st     <= ST_INIT;
                        end
                     end
                     M_ADDR: begin
                        rd_addr <= ADDR_W'(idx);
                        st      <= ST_FETCH;
                     end
                     M_CHAR: begin
                        idx <= idx_n;
                        if (idx_n == 6'(NUM_CHARS)) begin
                           done <= 1'b1;
                           st   <= ST_FIN;
                        end else if (idx_n == 6'd16) begin
                           st <= ST_ADDR;
                        end else begin
                           rd_addr <= ADDR_W'(idx_n);
                           st      <= ST_FETCH;
                        end
                     end
                     default: st <= ST_IDLE;
                  endcase
               end
            end
            ST_FIN: begin
               busy <= 1'b0;
               st   <= ST_IDLE;
            end
            default: st <= ST_PWRUP;
         endcase
      end
   end

   lcd_byte_tx #(
      .SETUP_CYC    (SETUP_CYC),
      .EN_CYC       (EN_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC)
   ) u_tx (
      .clk      (clk),
      .rst_n    (rst_i),
      .req      (req),
      .word     (word),
      .ack      (ack),
      .lcd_en   (lcd_en),
      .lcd_rs   (lcd_rs),
      .lcd_data (lcd_data)
   );

endmodule

// File: tb/tb_lcd_char_streamer.sv
// Bench for lcd_char_streamer: 32-char and 1-char instances,
// registered memory models, bus pulse capture and timing checks.
module tb_lcd_char_streamer;

   localparam int SETUP = 2;

   logic        clk;
   logic        rst_n;
   logic        d_start, o_start;
   logic [5:0]  d_addr, o_addr;
   logic [31:0] d_rd, o_rd;
   logic [7:0]  d_data, o_data;
   logic        d_rs, d_rw, d_en, d_busy, d_done;
   logic        o_rs, o_rw, o_en, o_busy, o_done;

   logic [8:0]  mem [64];
   logic [8:0]  mem1;

   typedef struct {
      logic [8:0] word;
      logic       rs;
      logic [7:0] data;
      int         extra;
   } vec_t;

   vec_t tbl [32];
   int   init_exp [4] = '{'h38, 'h0C, 'h06, 'h01};

   int total = 0;
   int bad   = 0;

   int p_rise [64];
   int p_fall [64];
   int p_len  [64];
   int p_rs   [64];
   int p_data [64];
   int p_addr [64];
   int n_p, ndone, done_cyc, viol, setup_bad, busy_bad;
   int max_ad, last_ad;

   lcd_char_streamer #(
      .NUM_CHARS(32), .ADDR_W(6), .PWRUP_CYC(20),
      .SETUP_CYC(SETUP), .EN_CYC(3),
      .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(9)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(d_start),
      .rd_addr(d_addr), .rd_data(d_rd),
      .lcd_data(d_data), .lcd_rs(d_rs), .lcd_rw(d_rw),
      .lcd_en(d_en), .busy(d_busy), .done(d_done)
   );

   lcd_char_streamer #(
      .NUM_CHARS(1), .ADDR_W(6), .PWRUP_CYC(20),
      .SETUP_CYC(SETUP), .EN_CYC(3),
      .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(9)
   ) u_one (
      .clk(clk), .rst_n(rst_n), .start(o_start),
      .rd_addr(o_addr), .rd_data(o_rd),
      .lcd_data(o_data), .lcd_rs(o_rs), .lcd_rw(o_rw),
      .lcd_en(o_en), .busy(o_busy), .done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle registered memories with junk in the unused upper bits.
   always @(posedge clk) begin
      d_rd <= {23'h2AAAAA, mem[d_addr]};
      o_rd <= {23'h555555, (o_addr == 6'd0) ? mem1 : 9'h1FF};
   end

   task automatic chk(input string nm, input int i,
                      input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d]: got 0x%0h want 0x%0h",
                  nm, i, act, exp);
      end
   endtask

   function automatic int gap(input int i);
      return p_rise[i+1] - p_fall[i];
   endfunction

   task automatic smp(input bit sel,
                      output logic en, output logic rs,
                      output logic bz, output logic dn,
                      output logic [7:0] dt, output logic [5:0] ad);
      if (sel) begin
         en = o_en; rs = o_rs; bz = o_busy;
         dn = o_done; dt = o_data; ad = o_addr;
      end else begin
         en = d_en; rs = d_rs; bz = d_busy;
         dn = d_done; dt = d_data; ad = d_addr;
      end
   endtask

   // Capture bus pulses of one instance until idle plus 60-cycle tail.
   task automatic run_pass(input bit sel, input bit do_start,
                           input bit dbl_start, input int limit);
      logic en, rs, bz, dn, pen, prs;
      logic [7:0] dt, pdt;
      logic [5:0] ad;
      int cyc, stable, tail;
      bit fin;
      n_p = 0; ndone = 0; done_cyc = -1; viol = 0;
      setup_bad = 0; busy_bad = 0; max_ad = 0; last_ad = 0;
      cyc = 0; stable = 0; tail = 0; fin = 0;
      smp(sel, en, rs, bz, dn, dt, ad);
      if (do_start) begin
         chk("idle_busy", sel, bz, 0);
         if (sel) o_start = 1'b1; else d_start = 1'b1;
         @(negedge clk);
         o_start = 1'b0; d_start = 1'b0;
         cyc = 1;
         smp(sel, en, rs, bz, dn, dt, ad);
         chk("busy_next", sel, bz, 1);
      end
      pen = en; prs = rs; pdt = dt;
      while (tail < 60) begin
         @(negedge clk);
         cyc++;
         if (dbl_start && cyc == 40) d_start = 1'b1;
         if (dbl_start && cyc == 41) d_start = 1'b0;
         smp(sel, en, rs, bz, dn, dt, ad);
         if (rs != prs || dt != pdt) begin
            if (en || pen) viol++;
            stable = 1;
         end else begin
            stable++;
         end
         if (int'(ad) > max_ad) max_ad = int'(ad);
         last_ad = int'(ad);
         if (en && !pen) begin
            if (n_p < 64) begin
               p_rise[n_p] = cyc;
               p_rs[n_p]   = int'(rs);
               p_data[n_p] = int'(dt);
               p_addr[n_p] = int'(ad);
               p_len[n_p]  = -1;
            end
            if (stable < SETUP + 1) setup_bad++;
            if (!bz) busy_bad++;
            n_p++;
         end
         if (!en && pen && n_p > 0 && n_p <= 64) begin
            p_len[n_p-1]  = cyc - p_rise[n_p-1];
            p_fall[n_p-1] = cyc;
         end
         if (dn) begin
            ndone++;
            done_cyc = cyc;
         end
         if (!fin && !bz && n_p > 0 && !en) fin = 1;
         if (fin) tail++;
         if (cyc > limit) begin
            chk("pass_timeout", sel, cyc, limit);
            break;
         end
         pen = en; prs = rs; pdt = dt;
      end
      chk("rs_data_moved_in_pulse", sel, viol, 0);
      chk("setup_short", sel, setup_bad, 0);
      chk("busy_low_in_pass", sel, busy_bad, 0);
   endtask

   task automatic check_stream(input bit with_init);
      int b, g0, i;
      b = with_init ? 4 : 0;
      chk("pulse_count", b, n_p, b + 34);
      if (with_init) begin
         for (int k = 0; k < 4; k++) begin
            chk("init_data", k, p_data[k], init_exp[k]);
            chk("init_rs", k, p_rs[k], 0);
         end
         chk("clr_hold_delta", 3, gap(3) - gap(2), 4);
         chk("cmd_hold_delta", 1, gap(1) - gap(0), 0);
      end
      chk("row0", b, p_data[b], 'h80);
      chk("row0_rs", b, p_rs[b], 0);
      chk("row1", b + 17, p_data[b+17], 'hC0);
      chk("row1_rs", b + 17, p_rs[b+17], 0);
      for (int k = 0; k < 32; k++) begin
         i = b + 1 + k + ((k >= 16) ? 1 : 0);
         chk("char_data", k, p_data[i], int'(tbl[k].data));
         chk("char_rs", k, p_rs[i], int'(tbl[k].rs));
         chk("char_addr", k, p_addr[i], k);
      end
      for (int j = 0; j < b + 34; j++)
         chk("en_len", j, p_len[j], 3);
      g0 = gap(b + 1);
      for (int k = 1; k < 31; k++) begin
         if (k != 15) begin
            i = b + 1 + k + ((k >= 16) ? 1 : 0);
            chk("hold_delta", k, gap(i) - g0, tbl[k].extra);
         end
      end
      chk("max_addr", 0, max_ad, 31);
      chk("final_addr", 0, last_ad, 31);
   endtask

   int la, lb, lc;

   initial begin
      rst_n = 1'b0; d_start = 1'b0; o_start = 1'b0;
      mem1 = 9'h148;
      for (int k = 0; k < 64; k++) mem[k] = 9'h0;
      for (int k = 0; k < 32; k++)
         tbl[k] = '{{1'b1, 8'(8'h41 + k)}, 1'b1, 8'(8'h41 + k), 0};
      tbl[3]  = '{9'h002, 1'b0, 8'h02, 4};
      tbl[7]  = '{9'h101, 1'b1, 8'h01, 0};
      tbl[12] = '{9'h004, 1'b0, 8'h04, 0};
      tbl[20] = '{9'h001, 1'b0, 8'h01, 4};
      tbl[25] = '{9'h003, 1'b0, 8'h03, 4};
      tbl[28] = '{9'h100, 1'b1, 8'h00, 0};
      for (int k = 0; k < 32; k++) mem[k] = tbl[k].word;

      repeat (3) @(negedge clk);
      chk("rst_en", 0, d_en, 0);
      chk("rst_rs", 0, d_rs, 0);
      chk("rst_data", 0, d_data, 0);
      chk("rst_rw", 0, d_rw, 0);
      chk("rst_addr", 0, d_addr, 0);
      chk("rst_busy", 0, d_busy, 1);
      chk("rst_done", 0, d_done, 0);
      chk("rst_busy", 1, o_busy, 1);

      rst_n = 1'b1;
      run_pass(0, 0, 0, 3000);
      chk("first_en_early", 0, int'(p_rise[0] >= 22), 1);
      chk("first_en_late", 0, int'(p_rise[0] <= 40), 1);
      check_stream(1);

      run_pass(0, 1, 1, 3000);
      check_stream(0);
      chk("done_count", 0, ndone, 1);
      chk("rw_const", 0, d_rw, 0);

      for (int w = 0; w < 500 && o_busy; w++) @(negedge clk);
      chk("one_idle", 1, o_busy, 0);

      mem1 = 9'h148;
      run_pass(1, 1, 0, 1000);
      chk("one_count", 1, n_p, 2);
      chk("one_row0", 1, p_data[0], 'h80);
      chk("one_row0_rs", 1, p_rs[0], 0);
      chk("one_char", 1, p_data[1], 'h48);
      chk("one_char_rs", 1, p_rs[1], 1);
      chk("one_addr", 1, p_addr[1], 0);
      chk("one_len0", 1, p_len[0], 3);
      chk("one_len1", 1, p_len[1], 3);
      chk("one_done", 1, ndone, 1);
      chk("one_max_addr", 1, max_ad, 0);
      la = done_cyc - p_fall[1];

      mem1 = 9'h002;
      run_pass(1, 1, 0, 1000);
      chk("home_char", 1, p_data[1], 'h02);
      chk("home_rs", 1, p_rs[1], 0);
      chk("home_done", 1, ndone, 1);
      lb = done_cyc - p_fall[1];

      mem1 = 9'h102;
      run_pass(1, 1, 0, 1000);
      chk("data02_rs", 1, p_rs[1], 1);
      chk("data02_done", 1, ndone, 1);
      lc = done_cyc - p_fall[1];
      chk("home_vs_data_hold", 1, lb - lc, 4);
      chk("data_vs_data_hold", 1, la - lc, 0);

      d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      for (int w = 0; w < 500 && !d_en; w++) @(negedge clk);
      chk("reach_pulse", 0, d_en, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_en", 0, d_en, 0);
      chk("async_data", 0, d_data, 0);
      chk("async_busy", 0, d_busy, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_pass(0, 0, 0, 3000);
      chk("restart_early", 0, int'(p_rise[0] >= 22), 1);
      chk("restart_late", 0, int'(p_rise[0] <= 40), 1);
      check_stream(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
